// File: rtl/round_referee_if.sv
// round_referee_if: key/end-light inputs and score/display outputs of the round referee
interface round_referee_if;
    logic       L;
    logic       R;
    logic       leftEnd;
    logic       rightEnd;
    logic       resetround;
    logic [2:0] leftScore;
    logic [2:0] rightScore;
    logic [1:0] winner;
    logic [6:0] hexLeft;
    logic [6:0] hexRight;
    modport master (
        output L, R, leftEnd, rightEnd,
        input  resetround, leftScore, rightScore, winner, hexLeft, hexRight
    );
    modport slave (
        input  L, R, leftEnd, rightEnd,
        output resetround, leftScore, rightScore, winner, hexLeft, hexRight
    );
endinterface

// File: rtl/round_referee.sv
// round_referee: scores tug-of-war points, re-centres the field and declares the match winner
module round_referee #(
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input logic          clk,
    input logic          reset,
    round_referee_if.slave bus
);
    typedef enum logic [1:0] {PLAY, HOLD, GAMEOVER} state_t;
    state_t     state, state_n;
    logic [2:0] ls, ls_n, rs, rs_n;
    logic [1:0] win, win_n;
    logic       rr, rr_n;
    logic [3:0] cnt, cnt_n;
    logic       lp, rp, last_pt;
    // Both end lights lit is an illegal field and never scores
    assign lp = bus.leftEnd & ~bus.rightEnd & bus.L & ~bus.R;
    assign rp = bus.rightEnd & ~bus.leftEnd & bus.R & ~bus.L;
    assign last_pt = (lp && ls == 3'(MAX_SCORE - 1)) || (rp && rs == 3'(MAX_SCORE - 1));
    always_comb begin
        state_n = state;
        ls_n    = ls;
        rs_n    = rs;
        win_n   = win;
        rr_n    = rr;
        cnt_n   = cnt;
        case (state)
            PLAY: if (lp || rp) begin
                ls_n    = lp ? ls + 3'd1 : ls;
                rs_n    = rp ? rs + 3'd1 : rs;
                rr_n    = 1'b1;
                state_n = last_pt ? GAMEOVER : HOLD;
                win_n   = last_pt ? (lp ? 2'b01 : 2'b10) : win;
                cnt_n   = last_pt ? cnt : 4'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                state_n = (cnt == 4'd0) ? PLAY : HOLD;
                rr_n    = (cnt != 4'd0);
                cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            end
            GAMEOVER: rr_n = 1'b1;
            default: state_n = PLAY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PLAY;
            ls    <= 3'd0;
            rs    <= 3'd0;
            win   <= 2'b00;
            rr    <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            ls    <= ls_n;
            rs    <= rs_n;
            win   <= win_n;
            rr    <= rr_n;
            cnt   <= cnt_n;
        end
    end
    function automatic logic [6:0] seg(input logic [2:0] d);
        case (d)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
    endfunction
    assign bus.resetround = rr;
    assign bus.leftScore  = ls;
    assign bus.rightScore = rs;
    assign bus.winner     = win;
    assign bus.hexLeft    = seg(ls);
    assign bus.hexRight   = seg(rs);
endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee: directed and random stimulus checked against an edge-count reference model
module tb_round_referee;
    localparam int MAX  = 7;
    localparam int HOLD = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    round_referee_if bus ();
    round_referee #(.MAX_SCORE(MAX), .HOLD_CYCLES(HOLD)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int last_pt = -1000;
    int el = 0, er = 0, ew = 0;
    logic [6:0] hex_tab [8];
    initial begin
        hex_tab[0] = 7'b1000000; hex_tab[1] = 7'b1111001; hex_tab[2] = 7'b0100100; hex_tab[3] = 7'b0110000;
        hex_tab[4] = 7'b0011001; hex_tab[5] = 7'b0010010; hex_tab[6] = 7'b0000010; hex_tab[7] = 7'b1111000;
    end
    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d observed %b expected %b", tag, edge_n, obs, exp);
        end
    endtask
    // A point counts only in play: not game over and past the re-centre window of the last point
    task automatic step(input logic l, input logic r, input logic le, input logic re, input logic rst);
        bus.L = l; bus.R = r; bus.leftEnd = le; bus.rightEnd = re; reset = rst;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            el = 0; er = 0; ew = 0; last_pt = edge_n - 1000;
        end else if (ew == 0 && edge_n > last_pt + HOLD && (l ^ r) && (le ^ re) && ((l && le) || (r && re))) begin
            if (l) el++; else er++;
            last_pt = edge_n;
            ew = (el == MAX) ? 1 : (er == MAX) ? 2 : 0;
        end
        #1;
        chk("resetround", 7'(bus.resetround), 7'(ew != 0 || edge_n - last_pt < HOLD));
        chk("leftScore", 7'(bus.leftScore), 7'(el));
        chk("rightScore", 7'(bus.rightScore), 7'(er));
        chk("winner", 7'(bus.winner), 7'(ew));
        chk("hexLeft", bus.hexLeft, hex_tab[el]);
        chk("hexRight", bus.hexRight, hex_tab[er]);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask
    initial begin
        bus.L = 0; bus.R = 0; bus.leftEnd = 0; bus.rightEnd = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(5);
        chk("reset_hexLeft", bus.hexLeft, 7'b1000000);
        step(1, 0, 1, 0, 0);
        chk("left_point_hex", bus.hexLeft, 7'b1111001);
        idle(5);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        idle(1);
        step(0, 1, 0, 1, 0);
        idle(1);
        step(0, 1, 0, 1, 0);
        idle(2);
        step(0, 1, 0, 1, 0);
        chk("right_two", 7'(bus.rightScore), 7'd2);
        idle(4);
        for (int k = 0; k < MAX; k++) begin
            step(1, 0, 1, 0, 0);
            idle(HOLD);
        end
        chk("left_wins", 7'(bus.winner), 7'b01);
        for (int k = 0; k < 6; k++) step(k[0], ~k[0], 1, k[1], 0);
        step(0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 1);
        chk("reset_mid_hold", 7'(bus.resetround), 7'd0);
        idle(2);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_referee.md
Name: round_referee

Overview:
- Downstream stage of the tug-of-war light row. It watches the two end lights and the conditioned key presses, and detects when a player pulls the light off their end.
- On each point it increments that player's score and pulses resetround back into every light cell to re-centre the play field.
- It drives the two score digits on the seven-segment displays and declares the match winner at MAX_SCORE.

Parameters:
- MAX_SCORE, 7: points needed to win the match; legal range 1..7.
- HOLD_CYCLES, 4: number of cycles resetround stays high after a point; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; clears the whole match
- L  input  1  left key press, already synchronized, one cycle per press
- R  input  1  right key press, already synchronized, one cycle per press
- leftEnd  input  1  lightOn of the leftmost light cell
- rightEnd  input  1  lightOn of the rightmost light cell
- resetround  output  1  re-centre request to all light cells; registered
- leftScore  output  3  left player points, 0..MAX_SCORE
- rightScore  output  3  right player points, 0..MAX_SCORE
- winner  output  2  00 = none, 01 = left, 10 = right; 11 is never driven
- hexLeft  output  7  active-low segments {g,f,e,d,c,b,a} showing leftScore
- hexRight  output  7  active-low segments showing rightScore

Behaviour:
- Reset values (synchronous, on the clk edge with reset=1):
  - state = PLAY
  - leftScore = rightScore = 0
  - winner = 00
  - resetround = 0
  - hold counter = 0
  - hexLeft = hexRight = 7'b1000000 (digit 0)
- Reset has priority over every transition, including mid-HOLD and in GAMEOVER.
- State machine states: PLAY, HOLD, GAMEOVER.
- Point detection is evaluated only in PLAY, on the sampling edge:
  - leftPoint = leftEnd & L & ~R
  - rightPoint = rightEnd & R & ~L
  - L and R both high means no point (same XOR rule the light cells use).
  - leftEnd and rightEnd both high is an illegal field; no point is scored and the state stays PLAY.
- PLAY → HOLD on leftPoint or rightPoint when the new score is below MAX_SCORE. On that edge:
  - the scoring player's score increments by 1
  - resetround becomes 1
  - the hold counter loads HOLD_CYCLES-1
- PLAY → GAMEOVER on a point that brings the score to MAX_SCORE. On that edge:
  - the score increments
  - winner is set (01 left, 10 right)
  - resetround becomes 1
- HOLD behaviour:
  - L, R, leftEnd and rightEnd are ignored.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, the state returns to PLAY and resetround returns to 0.
  - resetround is therefore high for exactly HOLD_CYCLES cycles.
  - The first possible new point is sampled on the edge after resetround falls.
- GAMEOVER behaviour:
  - Absorbing state; all inputs are ignored.
  - resetround is held at 1 continuously, so the field stays dark.
  - Scores and winner are frozen until reset.
- Latency: one cycle from the sampling edge to the updated score, resetround and hex outputs. All outputs are registered or decoded from registered state with no input-to-output combinational path.
- Scores never exceed MAX_SCORE and never wrap.
- The other player's score is unchanged on a point.
- Hex encoding (active-low {g..a}):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000

Test Plan:
- Reset for 2 cycles, then idle with all inputs 0 for 5 cycles → scores 0/0, winner 00, resetround 0, hexLeft = hexRight = 1000000.
- leftEnd=1, L=1 for one cycle → next cycle leftScore=1, hexLeft=1111001, resetround=1 for exactly 4 cycles, then 0; rightScore stays 0.
- leftEnd=1 with L=R=1 → no score change, resetround stays 0. Repeat with leftEnd=rightEnd=1, L=1 → no score change.
- Score a right point, then pulse R with rightEnd=1 on the 2nd HOLD cycle → rightScore stays 1. Pulse again 1 cycle after resetround falls → rightScore=2.
- Score 7 left points → leftScore=7, winner=01, resetround stuck at 1. Further L/R/end activity changes nothing. reset=1 → all outputs return to reset values.
- Assert reset on the 2nd HOLD cycle → next cycle state PLAY, scores 0, resetround 0.
